// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   exception_t   : fetch exception codes (ADEF = address error on fetch)
//   NOP           : instruction injected alongside a fetch exception
//   fetch_meta_t  : per-request metadata held while an icache request is in flight
//   fetch_size    : number of instructions a fetch at a given PC covers
package ifetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam logic [31:0] NOP              = 32'h0340_0000;

    typedef enum logic [0:0] {
        EXC_NONE = 1'b0,
        ADEF     = 1'b1
    } exception_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  size;
        logic        taken1;
        logic [31:0] target1;
        logic        taken2;
        logic [31:0] target2;
    } fetch_meta_t;

    // One instruction when starting on the upper word of the 8-byte line or
    // when slot 1 is predicted taken; otherwise two.
    function automatic logic [1:0] fetch_size(input logic [31:0] pc, input logic taken1);
        return (pc[2] || taken1) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/fetch_meta_fifo.sv
// Circular queue holding metadata for in-flight icache requests.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   clear               : drop all entries (takes priority over push/pop)
//   push, push_data     : enqueue one entry (ignored when full and not popping)
//   pop, pop_data       : dequeue head; pop_data always shows the head entry
//   full, empty, count  : occupancy status
module fetch_meta_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             push,
    input  fetch_meta_t                      push_data,
    input  logic                             pop,
    output fetch_meta_t                      pop_data,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH + 1) - 1 : 0] count
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_meta_t    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Pointer advance with explicit wrap so non-power-of-two depths also work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Status flags and guarded handshakes.
    always_comb begin
        full     = (count == CNT_W'(DEPTH));
        empty    = (count == '0);
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        pop_data = mem[rd_ptr];
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch front end feeding the instruction buffer.
// Owns the fetch PC, issues aligned one/two-word icache requests, tracks them
// in a metadata queue and turns in-order responses into 0/1/2-instruction
// bundles tagged with their branch prediction. Flush redirects the PC and
// discards responses to requests that were already in flight.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   flush, flush_target             : backend redirect
//   icache_req_*                    : request channel (word-aligned address)
//   icache_resp_valid/data          : in-order response {addr+4 word, addr word}
//   bpu_pc, bpu_taken*/target*      : predictor lookup for pc and pc+4
//   ibuf_ready                      : buffer can accept a full bundle
//   out_size, out_* slot 1/2        : delivered bundle (combinational with response)
//   have_exception, exception_type  : sticky fetch address exception
// Optional: define IFETCH_PERF_EN to add perf_req_cnt, perf_stall_cnt and
// perf_drop_cnt event counters.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        icache_req_valid,
    input  logic        icache_req_ready,
    output logic [31:0] icache_req_addr,
    input  logic        icache_resp_valid,
    input  logic [63:0] icache_resp_data,
    output logic [31:0] bpu_pc,
    input  logic        bpu_taken1,
    input  logic [31:0] bpu_target1,
    input  logic        bpu_taken2,
    input  logic [31:0] bpu_target2,
    input  logic        ibuf_ready,
    output logic [1:0]  out_size,
    output logic [31:0] out_pc1,
    output logic [31:0] out_inst1,
    output logic        out_pred_taken1,
    output logic [31:0] out_pred_target1,
    output logic [31:0] out_pc2,
    output logic [31:0] out_inst2,
    output logic        out_pred_taken2,
    output logic [31:0] out_pred_target2,
    output logic        have_exception,
    output exception_t  exception_type
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);

    localparam int unsigned OCC_W  = $clog2(MAX_OUTSTANDING + 1);
    // Discard count can exceed the queue depth after back-to-back flushes.
    localparam int unsigned DISC_W = OCC_W + 4;

    logic [31:0]       pc;
    logic              started;
    logic [DISC_W-1:0] discard;
    logic              exc_pending;

    logic              misaligned;
    logic [1:0]        cur_size;
    logic [31:0]       next_pc;
    logic              req_hs;
    logic              discard_active;
    logic              resp_live;
    logic              exc_fire;
    logic [DISC_W-1:0] inflight;
    logic [DISC_W-1:0] discard_on_flush;

    fetch_meta_t       push_meta;
    fetch_meta_t       head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [OCC_W-1:0]  fifo_count;

    // Request issue, next-PC selection and response/flush bookkeeping.
    always_comb begin
        misaligned = (pc[1:0] != 2'b00);
        cur_size   = fetch_size(pc, bpu_taken1);

        if (bpu_taken1) begin
            next_pc = bpu_target1;
        end else if (cur_size == 2'd2 && bpu_taken2) begin
            next_pc = bpu_target2;
        end else begin
            next_pc = pc + ((cur_size == 2'd2) ? 32'd8 : 32'd4);
        end

        icache_req_valid = started & ibuf_ready & ~fifo_full & ~have_exception
                         & ~flush & ~misaligned;
        icache_req_addr  = {pc[31:3], 3'b000};
        bpu_pc           = pc;
        req_hs           = icache_req_valid & icache_req_ready;

        push_meta.pc      = pc;
        push_meta.size    = cur_size;
        push_meta.taken1  = bpu_taken1;
        push_meta.target1 = bpu_target1;
        push_meta.taken2  = bpu_taken2;
        push_meta.target2 = bpu_target2;

        discard_active = (discard != '0);
        resp_live      = icache_resp_valid & ~flush & ~discard_active;

        exc_fire = started & misaligned & fifo_empty & ~discard_active
                 & ~have_exception & ~flush;

        // Everything still owed by the icache after a flush gets dropped; a
        // response arriving in the flush cycle itself is already accounted.
        inflight         = discard + DISC_W'(fifo_count) + DISC_W'(req_hs);
        discard_on_flush = (icache_resp_valid && inflight != '0)
                         ? inflight - DISC_W'(1) : inflight;
    end

    // Bundle assembly; slot 1 picks the word by the stored pc[2].
    always_comb begin
        out_size         = 2'd0;
        out_pc1          = head.pc;
        out_inst1        = head.pc[2] ? icache_resp_data[63:32] : icache_resp_data[31:0];
        out_pred_taken1  = head.taken1;
        out_pred_target1 = head.target1;
        out_pc2          = head.pc + 32'd4;
        out_inst2        = icache_resp_data[63:32];
        out_pred_taken2  = head.taken2;
        out_pred_target2 = head.target2;

        if (resp_live) begin
            out_size = head.size;
        end else if (exc_pending && !flush) begin
            out_size         = 2'd1;
            out_pc1          = pc;
            out_inst1        = NOP;
            out_pred_taken1  = 1'b0;
            out_pred_target1 = '0;
        end
    end

    // Fetch PC, discard counter and exception state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= RESET_PC;
            started        <= 1'b0;
            discard        <= '0;
            have_exception <= 1'b0;
            exception_type <= EXC_NONE;
            exc_pending    <= 1'b0;
        end else begin
            started <= 1'b1;
            if (flush) begin
                pc             <= flush_target;
                discard        <= discard_on_flush;
                have_exception <= 1'b0;
                exception_type <= EXC_NONE;
                exc_pending    <= 1'b0;
            end else begin
                if (req_hs) begin
                    pc <= next_pc;
                end
                if (icache_resp_valid && discard_active) begin
                    discard <= discard - DISC_W'(1);
                end
                exc_pending <= exc_fire;
                if (exc_fire) begin
                    have_exception <= 1'b1;
                    exception_type <= ADEF;
                end
            end
        end
    end

    fetch_meta_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_meta_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (req_hs),
        .push_data (push_meta),
        .pop       (resp_live),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef IFETCH_PERF_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_req_cnt   <= '0;
            perf_stall_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (req_hs) begin
                perf_req_cnt <= perf_req_cnt + 32'd1;
            end
            if (!ibuf_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (icache_resp_valid && (flush || discard_active)) begin
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;
    import ifetch_pkg::*;

    localparam int unsigned MAXO = 2;
    localparam logic [31:0] RPC  = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_target;
    logic        icache_req_valid;
    logic        icache_req_ready;
    logic [31:0] icache_req_addr;
    logic        icache_resp_valid;
    logic [63:0] icache_resp_data;
    logic [31:0] bpu_pc;
    logic        bpu_taken1;
    logic [31:0] bpu_target1;
    logic        bpu_taken2;
    logic [31:0] bpu_target2;
    logic        ibuf_ready;
    logic [1:0]  out_size;
    logic [31:0] out_pc1, out_inst1, out_pred_target1;
    logic        out_pred_taken1;
    logic [31:0] out_pc2, out_inst2, out_pred_target2;
    logic        out_pred_taken2;
    logic        have_exception;
    exception_t  exception_type;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_req_cnt, perf_stall_cnt, perf_drop_cnt;
`endif

    always #5 clk = ~clk;

    ifetch dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .flush_target     (flush_target),
        .icache_req_valid (icache_req_valid),
        .icache_req_ready (icache_req_ready),
        .icache_req_addr  (icache_req_addr),
        .icache_resp_valid(icache_resp_valid),
        .icache_resp_data (icache_resp_data),
        .bpu_pc           (bpu_pc),
        .bpu_taken1       (bpu_taken1),
        .bpu_target1      (bpu_target1),
        .bpu_taken2       (bpu_taken2),
        .bpu_target2      (bpu_target2),
        .ibuf_ready       (ibuf_ready),
        .out_size         (out_size),
        .out_pc1          (out_pc1),
        .out_inst1        (out_inst1),
        .out_pred_taken1  (out_pred_taken1),
        .out_pred_target1 (out_pred_target1),
        .out_pc2          (out_pc2),
        .out_inst2        (out_inst2),
        .out_pred_taken2  (out_pred_taken2),
        .out_pred_target2 (out_pred_target2),
        .have_exception   (have_exception),
        .exception_type   (exception_type)
`ifdef IFETCH_PERF_EN
        ,
        .perf_req_cnt     (perf_req_cnt),
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_drop_cnt    (perf_drop_cnt)
`endif
    );

    // Environment predictor: a taken branch is registered against a fetch PC.
    logic [31:0] t1_pc, t1_tgt, t2_pc, t2_tgt;
    always_comb begin
        bpu_taken1  = (bpu_pc == t1_pc);
        bpu_target1 = t1_tgt;
        bpu_taken2  = (bpu_pc == t2_pc);
        bpu_target2 = t2_tgt;
    end

    typedef struct {
        logic [31:0] line;
        bit          live;
        logic [1:0]  size;
        logic [31:0] pc;
        logic        t1;
        logic [31:0] g1;
        logic        t2;
        logic [31:0] g2;
    } pend_t;

    pend_t       pend_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] model_pc;
    int          exc_state;
    bit          first;
    bit          resp_en;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h9e37_79b9;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive icache response, check DUT against the model, advance.
    task automatic step();
        int          live_n;
        bit          exp_valid, hs, rv, exc_go;
        pend_t       e, ne;
        logic [31:0] ln;
        logic [1:0]  sz;
        sz = 2'd0;
        ne = '{default: '0};
        rv = resp_en && (pend_q.size() > 0);
        icache_resp_valid = rv;
        if (rv) begin
            ln = pend_q[0].line;
            icache_resp_data = {word(ln + 32'd4), word(ln)};
        end else begin
            icache_resp_data = '0;
        end
        #1;
        live_n = 0;
        foreach (pend_q[i]) if (pend_q[i].live) live_n++;
        exp_valid = !first && ibuf_ready && (live_n < MAXO) && !flush
                  && (model_pc[1:0] == 2'b00) && (exc_state == 0);
        chk("req_valid", 64'(icache_req_valid), 64'(exp_valid));
        hs = exp_valid && icache_req_ready;
        if (exp_valid) chk("req_addr", 64'(icache_req_addr), 64'({model_pc[31:3], 3'b000}));
        chk("have_exception", 64'(have_exception), 64'(exc_state != 0));
        if (exc_state != 0) chk("exception_type", 64'(exception_type), 64'(ADEF));
        if (rv && pend_q[0].live && !flush) begin
            e = pend_q[0];
            chk("out_size", 64'(out_size), 64'(e.size));
            chk("out_pc1", 64'(out_pc1), 64'(e.pc));
            chk("out_inst1", 64'(out_inst1), 64'(word(e.pc)));
            chk("out_pred_taken1", 64'(out_pred_taken1), 64'(e.t1));
            chk("out_pred_target1", 64'(out_pred_target1), 64'(e.g1));
            if (e.size == 2'd2) begin
                chk("out_pc2", 64'(out_pc2), 64'(e.pc + 32'd4));
                chk("out_inst2", 64'(out_inst2), 64'(word(e.pc + 32'd4)));
                chk("out_pred_taken2", 64'(out_pred_taken2), 64'(e.t2));
                chk("out_pred_target2", 64'(out_pred_target2), 64'(e.g2));
            end
        end else if (exc_state == 1 && !flush) begin
            chk("exc_out_size", 64'(out_size), 64'd1);
            chk("exc_out_pc1", 64'(out_pc1), 64'(model_pc));
            chk("exc_out_inst1", 64'(out_inst1), 64'(NOP));
        end else begin
            chk("out_size_idle", 64'(out_size), 64'd0);
        end
        if (hs) begin
            sz = (model_pc[2] || model_pc == t1_pc) ? 2'd1 : 2'd2;
            ne.line = {model_pc[31:3], 3'b000};
            ne.live = 1'b1;
            ne.size = sz;
            ne.pc   = model_pc;
            ne.t1   = (model_pc == t1_pc);
            ne.g1   = t1_tgt;
            ne.t2   = (model_pc == t2_pc);
            ne.g2   = t2_tgt;
        end
        exc_go = !first && !flush && (exc_state == 0) && (model_pc[1:0] != 2'b00)
               && (pend_q.size() == 0);
        @(posedge clk);
        if (rv) void'(pend_q.pop_front());
        if (hs) begin
            pend_q.push_back(ne);
            if (ne.t1)                    model_pc = ne.g1;
            else if (sz == 2'd2 && ne.t2) model_pc = ne.g2;
            else                          model_pc = model_pc + 32'(4 * sz);
        end
        if (flush) begin
            foreach (pend_q[i]) pend_q[i].live = 1'b0;
            model_pc  = flush_target;
            exc_state = 0;
        end else if (exc_go) begin
            exc_state = 1;
        end else if (exc_state == 1) begin
            exc_state = 2;
        end
        first = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_flush(input logic [31:0] tgt);
        flush        = 1'b1;
        flush_target = tgt;
        step();
        flush        = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        flush_target = '0;
        icache_req_ready = 1'b1;
        icache_resp_valid = 1'b0;
        icache_resp_data = '0;
        ibuf_ready = 1'b1;
        t1_pc = '0; t1_tgt = '0; t2_pc = '0; t2_tgt = '0;
        resp_en = 1'b1;
        exc_state = 0;
        model_pc = RPC;
        first = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_valid", 64'(icache_req_valid), 64'd0);
        chk("rst_out_size", 64'(out_size), 64'd0);
        chk("rst_have_exception", 64'(have_exception), 64'd0);
        chk("rst_bpu_pc", 64'(bpu_pc), 64'(RPC));
        reset = 1'b0;

        // Sequential fetch from reset
        run(6);

        // Odd start: single upper-word fetch
        do_flush(32'h1c00_0004);
        run(4);

        // Slot-2 predicted taken at 1c000010
        t2_pc  = 32'h1c00_0010;
        t2_tgt = 32'h1c00_0100;
        do_flush(32'h1c00_0010);
        run(4);
        t2_pc  = '0;

        // Flush with two requests in flight
        resp_en = 1'b0;
        run(3);
        do_flush(32'h1c00_0200);
        resp_en = 1'b1;
        run(6);

        // Backpressure from the instruction buffer
        ibuf_ready = 1'b0;
        run(5);
        ibuf_ready = 1'b1;
        run(3);

        // Misaligned redirect raises ADEF and stalls
        do_flush(32'h1c00_0002);
        run(7);
        do_flush(32'h1c00_0300);
        run(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
